// File: rtl/wb_slave_ram_if.sv
// Wishbone classic slave bus bundle for wb_slave_ram.
interface wb_slave_ram_if;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_ack_o;
    logic        wbs_err_o;

    modport slave (
        input  wbs_adr_i, wbs_dat_i, wbs_we_i, wbs_sel_i, wbs_stb_i, wbs_cyc_i,
        output wbs_dat_o, wbs_ack_o, wbs_err_o
    );

    modport master (
        output wbs_adr_i, wbs_dat_i, wbs_we_i, wbs_sel_i, wbs_stb_i, wbs_cyc_i,
        input  wbs_dat_o, wbs_ack_o, wbs_err_o
    );
endinterface

// File: rtl/wb_slave_ram.sv
// Wishbone slave RAM with byte-lane writes, configurable wait states and
// error termination for addresses outside the mapped window.
module wb_slave_ram #(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_i,
    wb_slave_ram_if.slave  wbs
);

    localparam int unsigned AW        = $clog2(MEM_WORDS);
    localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);
    localparam logic [3:0]  WS_LOAD   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic [31:0] adr_q, dat_q;
    logic        we_q;
    logic [3:0]  sel_q;
    logic        ack_q, err_q;
    logic [31:0] rdat_q;

    logic [31:0] mem [MEM_WORDS];

    logic          req_valid, fire, in_range, mem_wr;
    logic [31:0]   a_adr, a_dat, a_off;
    logic          a_we;
    logic [3:0]    a_sel;
    logic [AW-1:0] a_idx;

    // Zero-wait responses are served straight from the bus; otherwise the
    // values latched on acceptance are used so mid-wait bus changes are ignored.
    always_comb begin
        req_valid = wbs.wbs_cyc_i && wbs.wbs_stb_i;
        if (state == S_WAIT) begin
            a_adr = adr_q;
            a_dat = dat_q;
            a_we  = we_q;
            a_sel = sel_q;
        end else begin
            a_adr = wbs.wbs_adr_i;
            a_dat = wbs.wbs_dat_i;
            a_we  = wbs.wbs_we_i;
            a_sel = wbs.wbs_sel_i;
        end
        fire = !wb_rst_i && req_valid &&
               (((state == S_IDLE) && (WAIT_STATES == 0)) ||
                ((state == S_WAIT) && (wait_cnt == 4'd0)));
        a_off    = a_adr - BASE_ADDR;
        in_range = (a_adr >= BASE_ADDR) && (a_off < MEM_BYTES);
        a_idx    = a_off[AW+1:2];
        mem_wr   = fire && in_range && a_we;
    end

    always_ff @(posedge wb_clk_i) begin
        if (mem_wr) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (a_sel[b]) mem[a_idx][8*b +: 8] <= a_dat[8*b +: 8];
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rdat_q   <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        adr_q <= wbs.wbs_adr_i;
                        dat_q <= wbs.wbs_dat_i;
                        we_q  <= wbs.wbs_we_i;
                        sel_q <= wbs.wbs_sel_i;
                        if (WAIT_STATES == 0) begin
                            state <= S_RESP;
                        end else begin
                            wait_cnt <= WS_LOAD;
                            state    <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!req_valid)             state    <= S_IDLE;
                    else if (wait_cnt == 4'd0)  state    <= S_RESP;
                    else                        wait_cnt <= wait_cnt - 4'd1;
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
            if (fire) begin
                if (in_range) begin
                    ack_q <= 1'b1;
                    if (!a_we) rdat_q <= mem[a_idx];
                end else begin
                    err_q <= 1'b1;
                    if (!a_we) rdat_q <= '0;
                end
            end
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_err_o = err_q;
    assign wbs.wbs_dat_o = rdat_q;

endmodule

// File: tb/tb_wb_slave_ram.sv
// Directed bench for wb_slave_ram at WAIT_STATES 0, 1 and 3.
module tb_wb_slave_ram;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] adr = '0, dat = '0;
    logic        we = 1'b0, cyc = 1'b0, stb = 1'b0;
    logic [3:0]  sel = '0;
    int          tgt = 1;
    logic        ack_m, err_m;
    logic [31:0] dat_m;
    int          n_checks = 0;
    int          n_errs   = 0;

    always #5 clk = ~clk;

    wb_slave_ram_if b0 ();
    wb_slave_ram_if b1 ();
    wb_slave_ram_if b3 ();

    assign b0.wbs_adr_i = adr;  assign b1.wbs_adr_i = adr;  assign b3.wbs_adr_i = adr;
    assign b0.wbs_dat_i = dat;  assign b1.wbs_dat_i = dat;  assign b3.wbs_dat_i = dat;
    assign b0.wbs_we_i  = we;   assign b1.wbs_we_i  = we;   assign b3.wbs_we_i  = we;
    assign b0.wbs_sel_i = sel;  assign b1.wbs_sel_i = sel;  assign b3.wbs_sel_i = sel;
    assign b0.wbs_cyc_i = cyc && (tgt == 0);
    assign b1.wbs_cyc_i = cyc && (tgt == 1);
    assign b3.wbs_cyc_i = cyc && (tgt == 3);
    assign b0.wbs_stb_i = stb && (tgt == 0);
    assign b1.wbs_stb_i = stb && (tgt == 1);
    assign b3.wbs_stb_i = stb && (tgt == 3);

    wb_slave_ram #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0))
        u_ws0 (.wb_clk_i(clk), .wb_rst_i(rst), .wbs(b0));
    wb_slave_ram #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(1))
        u_ws1 (.wb_clk_i(clk), .wb_rst_i(rst), .wbs(b1));
    wb_slave_ram #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(3))
        u_ws3 (.wb_clk_i(clk), .wb_rst_i(rst), .wbs(b3));

    always_comb begin
        if (tgt == 0) begin
            ack_m = b0.wbs_ack_o; err_m = b0.wbs_err_o; dat_m = b0.wbs_dat_o;
        end else if (tgt == 1) begin
            ack_m = b1.wbs_ack_o; err_m = b1.wbs_err_o; dat_m = b1.wbs_dat_o;
        end else begin
            ack_m = b3.wbs_ack_o; err_m = b3.wbs_err_o; dat_m = b3.wbs_dat_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete access; lat is the number of edges from sampling to response, inclusive.
    task automatic xfer(input string tag, input int lat, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s, input logic exp_err,
                        output logic [31:0] rd);
        int n = 0;
        @(negedge clk);
        adr = a; dat = d; we = w; sel = s; cyc = 1'b1; stb = 1'b1;
        do begin
            @(posedge clk); #1; n++;
        end while (!(ack_m || err_m) && n < 20);
        check({tag, "_lat"}, 32'(n), 32'(lat));
        check({tag, "_ack"}, {31'b0, ack_m}, {31'b0, !exp_err});
        check({tag, "_err"}, {31'b0, err_m}, {31'b0, exp_err});
        rd = dat_m;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        check({tag, "_end"}, {30'b0, ack_m, err_m}, 32'h0);
    endtask

    // Hold a read strobe for eight edges and record which edges carry an ack.
    task automatic b2b(input string tag, input logic [7:0] exp_pat, input logic [31:0] a,
                       input logic [31:0] exp_d);
        logic [7:0] pat = '0;
        @(negedge clk);
        adr = a; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            pat[i] = ack_m;
            if (ack_m) check({tag, "_dat"}, dat_m, exp_d);
        end
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        check({tag, "_pat"}, {24'b0, pat}, {24'b0, exp_pat});
        repeat (3) @(posedge clk);
        #1;
    endtask

    logic [31:0] rd;
    logic        seen;
    int          n;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        for (int t = 0; t < 4; t++) begin
            if (t == 2) continue;
            tgt = t; #1;
            check("rst_out", {ack_m, err_m, 30'b0}, 32'h0);
            check("rst_dat", dat_m, 32'h0);
        end

        // First request on the first edge out of reset, one wait state.
        tgt = 1;
        @(negedge clk);
        rst = 1'b0; adr = 32'h10; dat = 32'hDEADBEEF; we = 1'b1; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        check("first_k", {31'b0, ack_m}, 32'h0);
        @(posedge clk); #1;
        check("first_k1", {30'b0, ack_m, err_m}, 32'h2);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        check("first_k2", {30'b0, ack_m, err_m}, 32'h0);

        xfer("rd10", 2, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd);
        check("rd10_dat", rd, 32'hDEADBEEF);

        xfer("ln_w1", 2, 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, rd);
        xfer("ln_w2", 2, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 1'b0, rd);
        xfer("ln_rd", 2, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, rd);
        check("ln_dat", rd, 32'h11BB33DD);
        xfer("sel0_w", 2, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 1'b0, rd);
        check("dat_hold", dat_m, 32'h11BB33DD);
        xfer("sel0_rd", 2, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, rd);
        check("sel0_dat", rd, 32'h11BB33DD);

        xfer("w0", 2, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, 1'b0, rd);
        xfer("oor_rd", 2, 1'b0, 32'h1000, 32'h0, 4'hF, 1'b1, rd);
        check("oor_dat", rd, 32'h0);
        xfer("oor_wr", 2, 1'b1, 32'h1000, 32'h55555555, 4'hF, 1'b1, rd);
        xfer("alias", 2, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0, rd);
        check("alias_dat", rd, 32'h0BADF00D);
        xfer("top_w", 2, 1'b1, 32'hFFC, 32'h76543210, 4'hF, 1'b0, rd);
        xfer("top_r", 2, 1'b0, 32'hFFF, 32'h0, 4'h0, 1'b0, rd);
        check("top_dat", rd, 32'h76543210);

        b2b("b2b1", 8'h92, 32'h10, 32'hDEADBEEF);

        tgt = 0;
        xfer("z_w", 1, 1'b1, 32'h8, 32'hC0FFEE00, 4'hF, 1'b0, rd);
        b2b("b2b0", 8'h55, 32'h8, 32'hC0FFEE00);

        tgt = 3;
        xfer("w3", 4, 1'b1, 32'h40, 32'h12345678, 4'hF, 1'b0, rd);

        // Strobe dropped one cycle after acceptance.
        @(negedge clk);
        adr = 32'h40; dat = 32'hCAFEF00D; we = 1'b1; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        stb = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ack_m || err_m) seen = 1'b1;
        end
        cyc = 1'b0;
        check("abort_resp", {31'b0, seen}, 32'h0);
        xfer("abort_rd", 4, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0, rd);
        check("abort_dat", rd, 32'h12345678);

        // Reset while waiting.
        @(negedge clk);
        adr = 32'h40; dat = 32'h99999999; we = 1'b1; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        @(posedge clk); #1;
        if (ack_m || err_m) seen = 1'b1;
        @(negedge clk);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (ack_m || err_m) seen = 1'b1;
        end
        check("rstw_resp", {31'b0, seen}, 32'h0);
        xfer("rstw_rd", 4, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0, rd);
        check("rstw_dat", rd, 32'h12345678);

        // Bus changes during the wait phase must not alter the latched access.
        @(negedge clk);
        adr = 32'h50; dat = 32'h0000AAAA; we = 1'b1; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        n = 1;
        @(negedge clk);
        adr = 32'h54; dat = 32'hFFFFFFFF; we = 1'b0; sel = 4'h0;
        do begin
            @(posedge clk); #1; n++;
        end while (!(ack_m || err_m) && n < 20);
        check("latch_lat", 32'(n), 32'd4);
        check("latch_ack", {30'b0, ack_m, err_m}, 32'h2);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        xfer("latch_rd", 4, 1'b0, 32'h50, 32'h0, 4'hF, 1'b0, rd);
        check("latch_dat", rd, 32'h0000AAAA);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
